// File: rtl/regfile_dump.sv
// Walks the register file two entries per read and streams (index, value) pairs over a valid/ready port.
// Optional build macro REGDUMP_SKIP_ZERO_EN suppresses entries whose value is zero.
module regfile_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        start,
    output logic [4:0]  ctrl_readRegA,
    output logic [4:0]  ctrl_readRegB,
    input  logic [31:0] data_readRegA,
    input  logic [31:0] data_readRegB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_index,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done
);

    localparam logic [5:0] FIRST6 = 6'(FIRST_REG);
    localparam logic [5:0] LAST6  = 6'(LAST_REG);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_EMIT_A, S_EMIT_B, S_DONE
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [5:0]  r_ptr, w_ptr_nxt;
    logic [31:0] r_bufA, r_bufB;
    logic [5:0]  w_ptr1, w_ptr2;
    logic        w_skipA, w_skipB;

    // 6-bit arithmetic so ptr+1/ptr+2 past 31 compare correctly instead of wrapping
    assign w_ptr1 = r_ptr + 6'd1;
    assign w_ptr2 = r_ptr + 6'd2;

`ifdef REGDUMP_SKIP_ZERO_EN
    assign w_skipA = (r_bufA == 32'd0);
    assign w_skipB = (r_bufB == 32'd0);
`else
    assign w_skipA = 1'b0;
    assign w_skipB = 1'b0;
`endif

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_state <= S_IDLE;
            r_ptr   <= 6'd0;
            r_bufA  <= 32'd0;
            r_bufB  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            if (r_state == S_READ) begin
                r_bufA <= data_readRegA;
                r_bufB <= data_readRegB;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        ctrl_readRegA = 5'd0;
        ctrl_readRegB = 5'd0;
        out_valid     = 1'b0;
        out_index     = 5'd0;
        out_data      = 32'd0;
        done          = 1'b0;
        busy          = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_READ;
                    w_ptr_nxt   = FIRST6;
                end
            end
            S_READ: begin
                ctrl_readRegA = r_ptr[4:0];
                ctrl_readRegB = (w_ptr1 > 6'd31) ? 5'd0 : w_ptr1[4:0];
                w_state_nxt   = S_EMIT_A;
            end
            S_EMIT_A: begin
                out_valid = ~w_skipA;
                out_index = r_ptr[4:0];
                out_data  = r_bufA;
                // a skipped slot advances exactly as if it had been accepted
                if (w_skipA || out_ready)
                    w_state_nxt = (w_ptr1 <= LAST6) ? S_EMIT_B : S_DONE;
            end
            S_EMIT_B: begin
                out_valid = ~w_skipB;
                out_index = w_ptr1[4:0];
                out_data  = r_bufB;
                if (w_skipB || out_ready) begin
                    if (w_ptr2 <= LAST6) begin
                        w_state_nxt = S_READ;
                        w_ptr_nxt   = w_ptr2;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: three instances (0..31, 4..8, 0..3) sharing one regfile model.
module tb_regfile_dump;

`ifdef REGDUMP_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b1;
    logic        start = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  sel = 2'd0;
    logic [31:0] rf [32];
    int          cyc = 0;

    logic [4:0]  ra [3], rb [3], ix [3];
    logic [31:0] da [3], db [3], dt [3];
    logic        vl [3], bs [3], dn [3];
    logic        st [3];

    logic [4:0]  o_ra, o_rb, o_idx;
    logic [31:0] o_dat;
    logic        o_valid, o_busy, o_done;

    int checks = 0;
    int errors = 0;

    int          g_idx [$];
    logic [31:0] g_dat [$];
    int          g_cyc [$];
    int          g_rd  [$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_rf
        assign da[g] = rf[ra[g]];
        assign db[g] = rf[rb[g]];
        assign st[g] = start & (sel == 2'(g));
    end

    regfile_dump u_a (
        .clock(clock), .ctrl_reset(ctrl_reset), .start(st[0]),
        .ctrl_readRegA(ra[0]), .ctrl_readRegB(rb[0]),
        .data_readRegA(da[0]), .data_readRegB(db[0]),
        .out_valid(vl[0]), .out_ready(out_ready), .out_index(ix[0]),
        .out_data(dt[0]), .busy(bs[0]), .done(dn[0]));

    regfile_dump #(.FIRST_REG(4), .LAST_REG(8)) u_b (
        .clock(clock), .ctrl_reset(ctrl_reset), .start(st[1]),
        .ctrl_readRegA(ra[1]), .ctrl_readRegB(rb[1]),
        .data_readRegA(da[1]), .data_readRegB(db[1]),
        .out_valid(vl[1]), .out_ready(out_ready), .out_index(ix[1]),
        .out_data(dt[1]), .busy(bs[1]), .done(dn[1]));

    regfile_dump #(.FIRST_REG(0), .LAST_REG(3)) u_c (
        .clock(clock), .ctrl_reset(ctrl_reset), .start(st[2]),
        .ctrl_readRegA(ra[2]), .ctrl_readRegB(rb[2]),
        .data_readRegA(da[2]), .data_readRegB(db[2]),
        .out_valid(vl[2]), .out_ready(out_ready), .out_index(ix[2]),
        .out_data(dt[2]), .busy(bs[2]), .done(dn[2]));

    always_comb begin
        o_ra = ra[sel]; o_rb = rb[sel]; o_idx = ix[sel]; o_dat = dt[sel];
        o_valid = vl[sel]; o_busy = bs[sel]; o_done = dn[sel];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Runs one dump on the selected instance and compares against a model built from rf.
    task automatic run_dump(input logic [1:0] s, input int first, input int last,
                            input int stall_idx, input int stall_n, input bit hold_start,
                            input string tag);
        int          e_idx [$];
        int          e_k [$];
        int          e_rd [$];
        logic [31:0] e_dat [$];
        int t0, done_cyc, stalled, bad, k_last;
        g_idx.delete(); g_dat.delete(); g_cyc.delete(); g_rd.delete();
        for (int i = first; i <= last; i++)
            if (!SKIP || rf[i] != 32'd0) begin
                e_idx.push_back(i); e_k.push_back(i - first); e_dat.push_back(rf[i]);
            end
        for (int p = first; p <= last; p += 2)
            e_rd.push_back(p * 32 + ((p + 1 > 31) ? 0 : p + 1));
        sel = s;
        out_ready = 1'b1;
        done_cyc = -1; stalled = 0; bad = 0;
        @(negedge clock);
        start = 1'b1;
        t0 = cyc;
        for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            if (!hold_start) start = 1'b0;
            out_ready = 1'b1;
            if (o_done) begin
                done_cyc = cyc;
                break;
            end
            if (!o_busy) bad++;
            if (o_valid) begin
                if (o_ra != 5'd0 || o_rb != 5'd0) bad++;
                if (int'(o_idx) == stall_idx && stalled < stall_n) begin
                    out_ready = 1'b0;
                    stalled++;
                    chk({tag, " stall index"}, 64'(o_idx), 64'(stall_idx));
                    chk({tag, " stall data"}, 64'(o_dat), 64'(rf[stall_idx]));
                end else begin
                    g_idx.push_back(int'(o_idx)); g_dat.push_back(o_dat); g_cyc.push_back(cyc - t0);
                end
            end else if (o_ra != 5'd0 || o_rb != 5'd0) begin
                g_rd.push_back(int'(o_ra) * 32 + int'(o_rb));
            end
        end
        chk({tag, " entry count"}, 64'(g_idx.size()), 64'(e_idx.size()));
        for (int j = 0; j < e_idx.size() && j < g_idx.size(); j++) begin
            chk({tag, " index"}, 64'(g_idx[j]), 64'(e_idx[j]));
            chk({tag, " data"}, 64'(g_dat[j]), 64'(e_dat[j]));
            // slot k is presented 2 + k + k/2 cycles after start, later by any stall
            chk({tag, " entry cycle"}, 64'(g_cyc[j]),
                64'(2 + e_k[j] + e_k[j] / 2 + ((stall_idx >= 0 && e_idx[j] >= stall_idx) ? stall_n : 0)));
        end
        chk({tag, " read count"}, 64'(g_rd.size()), 64'(e_rd.size()));
        for (int j = 0; j < e_rd.size() && j < g_rd.size(); j++)
            chk({tag, " read addr pair"}, 64'(g_rd[j]), 64'(e_rd[j]));
        chk({tag, " busy high / addr idle zero"}, 64'(bad), 64'd0);
        k_last = last - first;
        chk({tag, " done cycle"}, 64'(done_cyc < 0 ? -1 : done_cyc - t0),
            64'(3 + k_last + k_last / 2 + (stall_idx >= 0 ? stall_n : 0)));
        @(negedge clock);
        chk({tag, " done one cycle"}, 64'(o_done), 64'd0);
        chk({tag, " busy after done"}, 64'(o_busy), 64'd0);
        start = 1'b0;
        @(negedge clock);
        chk({tag, " no restart"}, 64'(o_busy), 64'd0);
    endtask

    typedef struct {
        logic [1:0]  dut;
        int          rg;
        logic [31:0] val;
        int          pos;
    } vec_t;

    initial begin
        vec_t tv [9];
        bit   found;

        tv[0] = '{2'd1, 4, 32'd5, 0};
        tv[1] = '{2'd1, 5, 32'd3, 1};
        tv[2] = '{2'd1, 6, 32'd8, 2};
        tv[3] = '{2'd1, 7, 32'd2, 3};
        tv[4] = '{2'd1, 8, 32'd0, SKIP ? -1 : 4};
        tv[5] = '{2'd2, 0, 32'd7, 0};
        tv[6] = '{2'd2, 1, 32'd0, SKIP ? -1 : 1};
        tv[7] = '{2'd2, 2, 32'd9, SKIP ? 1 : 2};
        tv[8] = '{2'd2, 3, 32'd0, SKIP ? -1 : 3};

        for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);

        repeat (2) @(negedge clock);
        chk("reset busy", 64'(o_busy), 64'd0);
        chk("reset done", 64'(o_done), 64'd0);
        chk("reset valid", 64'(o_valid), 64'd0);
        chk("reset index", 64'(o_idx), 64'd0);
        chk("reset data", 64'(o_dat), 64'd0);
        chk("reset readA", 64'(o_ra), 64'd0);
        chk("reset readB", 64'(o_rb), 64'd0);
        ctrl_reset = 1'b0;
        @(negedge clock);

        run_dump(2'd0, 0, 31, -1, 0, 1'b0, "full");
        run_dump(2'd0, 0, 31, 2, 3, 1'b0, "stall");
        run_dump(2'd0, 0, 31, -1, 0, 1'b1, "hold start");

        // reset while index 5 (EMIT_B slot) is waiting for the consumer
        sel = 2'd0;
        found = 1'b0;
        @(negedge clock);
        start = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            start = 1'b0;
            out_ready = 1'b1;
            if (o_valid && o_idx == 5'd5) begin
                out_ready = 1'b0;
                found = 1'b1;
                break;
            end
        end
        chk("mid reset reached index 5", 64'(found), 64'd1);
        #1 ctrl_reset = 1'b1;
        #1;
        chk("mid reset valid", 64'(o_valid), 64'd0);
        chk("mid reset busy", 64'(o_busy), 64'd0);
        chk("mid reset index", 64'(o_idx), 64'd0);
        @(negedge clock);
        ctrl_reset = 1'b0;
        out_ready = 1'b1;
        run_dump(2'd0, 0, 31, -1, 0, 1'b0, "after reset");

        for (int d = 1; d <= 2; d++) begin
            for (int v = 0; v < 9; v++)
                if (tv[v].dut == 2'(d)) rf[tv[v].rg] = tv[v].val;
            run_dump(2'(d), d == 1 ? 4 : 0, d == 1 ? 8 : 3, -1, 0, 1'b0, d == 1 ? "range4_8" : "range0_3");
            for (int v = 0; v < 9; v++) begin
                if (tv[v].dut != 2'(d)) continue;
                if (tv[v].pos >= 0) begin
                    chk("table index", 64'(tv[v].pos < g_idx.size() ? g_idx[tv[v].pos] : -1), 64'(tv[v].rg));
                    chk("table data", 64'(tv[v].pos < g_dat.size() ? g_dat[tv[v].pos] : 32'hdead_beef), 64'(tv[v].val));
                end else begin
                    found = 1'b0;
                    foreach (g_idx[j]) if (g_idx[j] == tv[v].rg) found = 1'b1;
                    chk("table skipped absent", 64'(found), 64'd0);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
